// File: rtl/alu_muldiv_if.sv
// Bus bundle for the multi-cycle multiply/divide unit: launch/operands,
// MTHI/MTLO writes, and the status/result outputs.
interface alu_muldiv_if #(
   parameter int WIDTH = 32
) ();
   logic             start;
   logic [1:0]       op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             hi_we;
   logic             lo_we;
   logic [WIDTH-1:0] wdata;
   logic             busy;
   logic             done;
   logic             dz;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;

   modport master (
      output start, op, a, b, hi_we, lo_we, wdata,
      input  busy, done, dz, hi, lo
   );

   modport slave (
      input  start, op, a, b, hi_we, lo_we, wdata,
      output busy, done, dz, hi, lo
   );
endinterface

// File: rtl/alu_muldiv.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// Operands are reduced to magnitudes at launch, processed one bit per cycle
// (shift-add multiply or restoring divide), then sign-corrected and written
// back in a single FIX cycle. Latency is WIDTH+1 cycles for every operand.
module alu_muldiv #(
   parameter int WIDTH = 32
) (
   input logic         clk,
   input logic         clrn,
   alu_muldiv_if.slave bus
);
   localparam int CNT_W = $clog2(WIDTH);
   localparam int W2    = 2 * WIDTH;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_FIX  = 2'd2
   } state_t;

   // Magnitude of a two's-complement value; MIN maps to 2^(WIDTH-1) unsigned.
   function automatic logic [WIDTH-1:0] f_abs(input logic signed [WIDTH-1:0] v);
      return v[WIDTH-1] ? $unsigned(-v) : $unsigned(v);
   endfunction

   // Conditional two's-complement negation, single width.
   function automatic logic [WIDTH-1:0] f_negw(input logic [WIDTH-1:0] v, input logic en);
      return en ? (~v + WIDTH'(1)) : v;
   endfunction

   // Conditional two's-complement negation, double width (full product).
   function automatic logic [W2-1:0] f_neg2(input logic [W2-1:0] v, input logic en);
      return en ? (~v + W2'(1)) : v;
   endfunction

   state_t            r_state;
   state_t            w_state_nx;
   logic [CNT_W-1:0]  r_cnt;
   logic              r_done;
   logic              r_dz;
   logic [WIDTH-1:0]  r_hi;
   logic [WIDTH-1:0]  r_lo;

   logic              r_is_div;
   logic              r_neg_q;
   logic              r_neg_r;
   logic              r_bz;
   logic [WIDTH-1:0]  r_hw;
   logic [WIDTH-1:0]  r_lw;
   logic [WIDTH-1:0]  r_opb;

   logic              w_launch;
   logic              w_step;
   logic              w_wb;
   logic              w_mthi;
   logic              w_mtlo;
   logic              w_busy;

   logic signed [WIDTH-1:0] w_a_s;
   logic signed [WIDTH-1:0] w_b_s;
   logic              w_signed;
   logic              w_a_neg;
   logic              w_b_neg;
   logic [WIDTH-1:0]  w_a_mag;
   logic [WIDTH-1:0]  w_b_mag;

   logic [WIDTH:0]    w_sum;
   logic [WIDTH:0]    w_trial;
   logic [WIDTH-1:0]  w_hw_nx;
   logic [WIDTH-1:0]  w_lw_nx;

   logic [W2-1:0]     w_prod;
   logic [WIDTH-1:0]  w_quo;
   logic [WIDTH-1:0]  w_rem;
   logic [WIDTH-1:0]  w_hi_res;
   logic [WIDTH-1:0]  w_lo_res;

   // State register; reset abandons any in-flight operation.
   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nx;
      end
   end

   // Next state and control strobes; start has priority over MTHI/MTLO in IDLE.
   always_comb begin
      w_state_nx = r_state;
      w_launch   = 1'b0;
      w_step     = 1'b0;
      w_wb       = 1'b0;
      w_mthi     = 1'b0;
      w_mtlo     = 1'b0;
      w_busy     = 1'b1;
      case (r_state)
         S_IDLE: begin
            w_busy = 1'b0;
            if (bus.start) begin
               w_launch   = 1'b1;
               w_state_nx = S_RUN;
            end else begin
               w_mthi = bus.hi_we;
               w_mtlo = bus.lo_we;
            end
         end
         S_RUN: begin
            w_step = 1'b1;
            if (r_cnt == CNT_W'(WIDTH - 1)) begin
               w_state_nx = S_FIX;
            end
         end
         S_FIX: begin
            w_wb       = 1'b1;
            w_state_nx = S_IDLE;
         end
         default: begin
            w_state_nx = S_IDLE;
         end
      endcase
   end

   // Launch-time operand conditioning: magnitudes for signed ops, raw otherwise.
   always_comb begin
      w_a_s    = bus.a;
      w_b_s    = bus.b;
      w_signed = ~bus.op[0];
      w_a_neg  = w_signed & bus.a[WIDTH-1];
      w_b_neg  = w_signed & bus.b[WIDTH-1];
      w_a_mag  = w_signed ? f_abs(w_a_s) : bus.a;
      w_b_mag  = w_signed ? f_abs(w_b_s) : bus.b;
   end

   // One iteration: shift-add for multiply, restoring shift-subtract for divide.
   always_comb begin
      w_sum   = {1'b0, r_hw} + (r_lw[0] ? {1'b0, r_opb} : '0);
      w_trial = {r_hw, r_lw[WIDTH-1]};
      w_hw_nx = r_hw;
      w_lw_nx = r_lw;
      if (r_is_div) begin
         if (w_trial >= {1'b0, r_opb}) begin
            w_hw_nx = WIDTH'(w_trial - {1'b0, r_opb});
            w_lw_nx = {r_lw[WIDTH-2:0], 1'b1};
         end else begin
            w_hw_nx = w_trial[WIDTH-1:0];
            w_lw_nx = {r_lw[WIDTH-2:0], 1'b0};
         end
      end else begin
         w_hw_nx = w_sum[WIDTH:1];
         w_lw_nx = {w_sum[0], r_lw[WIDTH-1:1]};
      end
   end

   // Sign correction and result selection for writeback.
   always_comb begin
      w_prod   = f_neg2({r_hw, r_lw}, r_neg_q);
      w_quo    = f_negw(r_lw, r_neg_q);
      w_rem    = f_negw(r_hw, r_neg_r);
      w_hi_res = w_prod[W2-1:WIDTH];
      w_lo_res = w_prod[WIDTH-1:0];
      if (r_is_div) begin
         w_hi_res = w_rem;
         w_lo_res = r_bz ? '1 : w_quo;
      end
   end

   // Working datapath: loaded at launch, advanced each RUN cycle.
   always_ff @(posedge clk) begin
      if (w_launch) begin
         r_is_div <= bus.op[1];
         r_neg_q  <= w_a_neg ^ w_b_neg;
         r_neg_r  <= w_a_neg;
         r_bz     <= (bus.b == '0);
         r_hw     <= '0;
         r_lw     <= bus.op[1] ? w_a_mag : w_b_mag;
         r_opb    <= bus.op[1] ? w_b_mag : w_a_mag;
      end else if (w_step) begin
         r_hw <= w_hw_nx;
         r_lw <= w_lw_nx;
      end
   end

   // Iteration counter, done pulse, sticky divide-by-zero flag.
   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         r_cnt  <= '0;
         r_done <= 1'b0;
         r_dz   <= 1'b0;
      end else begin
         r_done <= w_wb;
         if (w_launch) begin
            r_cnt <= '0;
            r_dz  <= 1'b0;
         end else if (w_step) begin
            r_cnt <= r_cnt + CNT_W'(1);
         end
         if (w_wb && r_is_div && r_bz) begin
            r_dz <= 1'b1;
         end
      end
   end

   // Architectural HI/LO: written only at writeback or by MTHI/MTLO in IDLE.
   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         r_hi <= '0;
         r_lo <= '0;
      end else if (w_wb) begin
         r_hi <= w_hi_res;
         r_lo <= w_lo_res;
      end else begin
         if (w_mthi) r_hi <= bus.wdata;
         if (w_mtlo) r_lo <= bus.wdata;
      end
   end

   assign bus.busy = w_busy;
   assign bus.done = r_done;
   assign bus.dz   = r_dz;
   assign bus.hi   = r_hi;
   assign bus.lo   = r_lo;
endmodule

// File: doc/alu_muldiv.md
Name: alu_muldiv

Overview:
Parametrised multi-cycle multiply/divide unit with architectural HI/LO registers. It is the sequential companion to the single-cycle ALU in the EX stage.
- Executes MULT/MULTU/DIV/DIVU iteratively, one bit per cycle.
- Holds results in HI/LO for MFHI/MFLO.
- Accepts MTHI/MTLO writes.
- Raises busy so the pipeline stalls on dependent HI/LO accesses.

Parameters:
WIDTH, 32, operand width and HI/LO width; any value >= 4.

Ports:
clk  in  1  rising-edge clock
clrn  in  1  asynchronous active-low reset
start  in  1  launch operation; sampled only when busy=0
op  in  2  00 MULT signed, 01 MULTU, 10 DIV signed, 11 DIVU
a  in  WIDTH  multiplicand / dividend (rs)
b  in  WIDTH  multiplier / divisor (rt)
hi_we  in  1  MTHI write enable
lo_we  in  1  MTLO write enable
wdata  in  WIDTH  MTHI/MTLO data
busy  out  1  operation in progress
done  out  1  one-cycle pulse: HI/LO just updated by an operation
dz  out  1  last divide had divisor 0; sticky until next start
hi  out  WIDTH  HI register
lo  out  WIDTH  LO register

Behaviour:
- Reset (clrn=0, asynchronous): state=IDLE; hi=lo=0; busy=done=dz=0; iteration counter=0. Any in-flight operation is abandoned; nothing is written back.
- States:
  - IDLE: busy=0.
  - RUN: WIDTH iterations.
  - FIX: sign correction and writeback.
- Launch (IDLE, start=1 at edge E0):
  - Latch op.
  - Latch |a| and |b| for signed ops; raw values for unsigned ops.
  - Latch result sign bits.
  - Clear counter; busy=1 after E0; go to RUN.
  - dz is cleared at E0. For DIV/DIVU with b=0, dz is set at writeback.
- RUN: edges E1..E_WIDTH, one iteration per edge.
  - Multiply: shift-add, 2*WIDTH-bit product.
  - Divide: restoring shift-subtract, WIDTH-bit quotient and remainder.
  - At E_WIDTH go to FIX.
- FIX: edge E_(WIDTH+1).
  - Negate results as required.
  - Write hi/lo; busy=0; done=1 for exactly the following cycle; return to IDLE.
  - Total latency: result visible WIDTH+1 cycles after start edge. Latency is fixed for all operands, including divide-by-zero.
- Result rules:
  - MULT/MULTU: {hi,lo} = full 2*WIDTH-bit product (signed or unsigned).
  - DIV/DIVU: lo = quotient, truncated toward zero. hi = remainder, with the sign of the dividend.
  - Divide by zero: lo = all ones; hi = a as latched; dz=1.
  - Signed overflow (MIN / -1): lo = MIN, hi = 0; dz=0; no trap.
- Start while busy: ignored; no queueing; in-flight operation unaffected.
- hi_we/lo_we:
  - IDLE with start=0: write wdata at the edge. Both may be asserted together; both registers receive wdata.
  - While busy: ignored.
  - IDLE with start=1 in the same cycle: start wins; the write is dropped.
- hi/lo are stable throughout RUN/FIX. They change only at writeback, MTHI/MTLO, or reset.
- start with op held is sampled once. A start held high after done re-launches in the first IDLE cycle.

Test Plan:
- WIDTH=32, MULT a=FFFFFFFD (-3), b=00000005 -> busy for 33 cycles; done pulse; hi=FFFFFFFF, lo=FFFFFFF1.
- MULTU a=b=FFFFFFFF -> hi=FFFFFFFE, lo=00000001. Then MULT with same operands -> hi=00000000, lo=00000001.
- DIV a=FFFFFFF9 (-7), b=00000002 -> lo=FFFFFFFD, hi=FFFFFFFF. Then DIVU a=7, b=2 -> lo=3, hi=1.
- Divide corner cases:
  - DIVU a=00000007, b=0 -> dz=1, lo=FFFFFFFF, hi=00000007, latency still 33.
  - DIV a=80000000, b=FFFFFFFF -> lo=80000000, hi=0, dz=0.
- Hazards:
  - Second start at cycle 5 of a MULT -> ignored; first result correct; only one done pulse.
  - hi_we during busy -> hi unchanged.
  - MTLO 12345678 in IDLE -> lo=12345678 next cycle.
  - start+lo_we same cycle -> lo keeps the old value until writeback.
- Reset and parametrisation:
  - Assert clrn=0 at cycle 10 of a DIV -> hi=lo=0, busy=done=dz=0 immediately.
  - After release, a new MULT 6*7 -> lo=0000002A, hi=0.
  - Repeat the MULT/DIV vectors at WIDTH=8: MULT F D(-3)*05 -> hi=FF, lo=F1; latency 9.
